// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO burst reader: parameter defaults, state
// encoding and a small saturating-counter helper.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer between the FIFO read port and the downstream
// valid/ready interface; head is the oldest stored word.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && (occ != 2'd0);
  assign do_push = push && ((occ != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Burst reader: pulls burst_len words from a FIFO with one-cycle read latency
// and forwards them in order over a valid/ready stream via a skid buffer.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  empty,
  input  logic                  underflow,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [7:0]            words_read,
  output logic                  err_underflow
);

  if (FIFO_DEPTH < 1) begin : g_depth_check
    $error("fifo_reader: FIFO_DEPTH must be at least 1");
  end

  rd_state_e  state;
  rd_state_e  state_nxt;
  logic [7:0] remaining;
  logic       inflight;
  logic       push;
  logic       pop;
  logic       accept;
  logic [1:0] occ;
  logic [1:0] occ_nxt;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  assign push    = inflight && !underflow;
  assign accept  = (state == IDLE) && start;
  assign busy    = (state != IDLE);
  assign occ_nxt = occ + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (burst_len == 8'd0) ? DONE : READ;
        end
      end
      READ: begin
        // Never let buffered plus in-flight words exceed the two skid slots.
        rd_en = !empty && (remaining != 8'd0) &&
                (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
        if ((remaining == 8'd0) || ((remaining == 8'd1) && rd_en)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // rd_en is low here, so the post-edge in-flight count is zero; leave
        // as soon as the buffer will be empty after this edge.
        if (occ_nxt == 2'd0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      remaining     <= 8'd0;
      inflight      <= 1'b0;
      words_read    <= 8'd0;
      err_underflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_en;
      if (accept) begin
        remaining <= burst_len;
      end else if (rd_en) begin
        remaining <= remaining - 8'd1;
      end
      if (accept) begin
        words_read <= 8'd0;
      end else if (pop) begin
        words_read <= sat_inc8(words_read);
      end
      if (accept) begin
        err_underflow <= 1'b0;
      end else if (inflight && underflow) begin
        err_underflow <= 1'b1;
      end
    end
  end

  fifo_rd_skid #(
    .WIDTH(FIFO_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (data_out),
    .pop       (pop),
    .occ       (occ),
    .head      (m_data)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a behavioural FIFO with one-cycle read
// latency, a per-cycle vector table and hand-written burst sequences.
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  burst_len = 8'd0;
  logic        busy, done, rd_en, m_valid;
  logic [15:0] data_out = 16'h0;
  logic        empty = 1'b1;
  logic        underflow = 1'b0;
  logic [15:0] m_data;
  logic        m_ready = 1'b1;
  logic [7:0]  words_read;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;

  fifo_reader #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .rd_en(rd_en), .data_out(data_out),
    .empty(empty), .underflow(underflow), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .words_read(words_read),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Behavioural source FIFO: data appears the cycle after rd_en.
  logic [15:0] fq [$];
  always @(posedge clk) begin
    if (rd_en && fq.size() != 0) begin
      data_out <= fq.pop_front();
      empty    <= (fq.size() == 0);
    end
  end

  task automatic push_word(input logic [15:0] w);
    fq.push_back(w);
    empty = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_rd_en"}, rd_en, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_m_valid"}, m_valid, 0);
    chk({p, "_m_data"}, m_data, 0);
    chk({p, "_words_read"}, words_read, 0);
    chk({p, "_err"}, err_underflow, 0);
  endtask

  // Burst runner observations
  logic [15:0] got [$];
  logic [15:0] late_w [2];
  int done_cnt, done_at, max_out, hold_err, rd_empty;

  task automatic run_burst(input int len, input int stall_from, input int stall_to,
                           input int late_at, input int uf_at, input int budget);
    int rd_total, pop_total;
    logic prev_hold;
    logic [15:0] prev_data;
    got.delete();
    done_cnt = 0; done_at = -1; max_out = 0; hold_err = 0; rd_empty = 0;
    rd_total = 0; pop_total = 0; prev_hold = 1'b0; prev_data = 16'h0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      start     = (cyc == 0);
      burst_len = (cyc == 0) ? len[7:0] : 8'd0;
      m_ready   = !((cyc >= stall_from) && (cyc <= stall_to));
      underflow = (cyc == uf_at);
      if (cyc == late_at) begin
        push_word(late_w[0]);
        push_word(late_w[1]);
      end
      #1;
      if (prev_hold && (!m_valid || m_data !== prev_data)) hold_err++;
      if (rd_en && empty) rd_empty++;
      if (rd_total - pop_total > max_out) max_out = rd_total - pop_total;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (m_valid && m_ready) got.push_back(m_data);
      rd_total  += int'(rd_en);
      pop_total += int'(m_valid && m_ready);
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      if (done_at >= 0 && cyc > done_at) break;
      @(posedge clk); #1;
    end
    start = 1'b0; underflow = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_words(input string name, input logic [15:0] exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s_word%0d", name, i), got[i], exp[i]);
    end
  endtask

  typedef struct {
    logic        start;
    logic [7:0]  len;
    logic        rdy;
    logic        rd_en;
    logic        m_valid;
    logic [15:0] m_data;
    logic        done;
    logic        busy;
    logic [7:0]  wr;
  } vec_t;

  vec_t vecs [13];
  logic [15:0] exp_q [$];

  initial begin
    // 5-word burst from t=0 (plus an ignored start at t+3), then a zero-length burst.
    vecs[0]  = '{1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'd0};
    vecs[2]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'd0};
    vecs[3]  = '{1'b1, 8'd0, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b1, 8'd0};
    vecs[4]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b1, 8'd1};
    vecs[5]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b1, 8'd2};
    vecs[6]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b1, 8'd3};
    vecs[7]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b1, 8'd4};
    vecs[8]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'd5};
    vecs[9]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd5};
    vecs[10] = '{1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd5};
    vecs[11] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'd0};
    vecs[12] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0};

    #12;
    chk_zero("reset");
    #4;
    rst_n = 1'b1;

    for (int w = 1; w <= 5; w++) push_word(16'(w));
    for (int i = 0; i < 13; i++) begin
      start = vecs[i].start; burst_len = vecs[i].len; m_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_rd_en", i), rd_en, vecs[i].rd_en);
      chk($sformatf("vec%0d_m_valid", i), m_valid, vecs[i].m_valid);
      if (vecs[i].m_valid) chk($sformatf("vec%0d_m_data", i), m_data, vecs[i].m_data);
      chk($sformatf("vec%0d_done", i), done, vecs[i].done);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_words_read", i), words_read, vecs[i].wr);
      @(posedge clk); #1;
    end
    start = 1'b0;

    // Downstream back-pressure for three cycles mid-burst.
    for (int w = 0; w < 4; w++) push_word(16'h000A + 16'(w));
    run_burst(4, 4, 6, -1, -1, 40);
    exp_q = {16'h000A, 16'h000B, 16'h000C, 16'h000D};
    chk_words("bp", exp_q);
    chk("bp_words_read", words_read, 4);
    chk("bp_done_cnt", done_cnt, 1);
    chk("bp_done_at", done_at, 10);
    chk("bp_max_outstanding_le2", (max_out <= 2), 1);
    chk("bp_hold_err", hold_err, 0);
    chk("bp_err_underflow", err_underflow, 0);

    // Source runs dry after two words; two more arrive at cycle 10.
    push_word(16'h0C01); push_word(16'h0C02);
    late_w[0] = 16'h0C03; late_w[1] = 16'h0C04;
    run_burst(4, -1, -1, 10, -1, 40);
    exp_q = {16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04};
    chk_words("stall", exp_q);
    chk("stall_rd_when_empty", rd_empty, 0);
    chk("stall_done_cnt", done_cnt, 1);
    chk("stall_done_at", done_at, 14);
    chk("stall_words_read", words_read, 4);

    // Underflow on the second capture cycle drops that word.
    push_word(16'h0011); push_word(16'h0022); push_word(16'h0033);
    run_burst(3, -1, -1, -1, 3, 40);
    exp_q = {16'h0011, 16'h0033};
    chk_words("uf", exp_q);
    chk("uf_words_read", words_read, 2);
    chk("uf_done_at", done_at, 6);
    chk("uf_err_sticky", err_underflow, 1);
    start = 1'b1; burst_len = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("uf_clear_on_start", err_underflow, 0);
    chk("uf_zero_done", done, 1);
    @(posedge clk); #1;

    // Reset mid-burst with two words sitting in the skid buffer.
    for (int w = 1; w <= 4; w++) push_word(16'h00E0 + 16'(w));
    start = 1'b1; burst_len = 8'd4; m_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst_pre_m_valid", m_valid, 1);
    chk("rst_pre_m_data", m_data, 16'h00E1);
    chk("rst_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk); #1;
    chk("midrst_no_done", done, 0);
    rst_n = 1'b1;
    fq.delete();
    empty = 1'b1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    push_word(16'h0051); push_word(16'h0052);
    run_burst(2, -1, -1, -1, -1, 40);
    exp_q = {16'h0051, 16'h0052};
    chk_words("post_rst", exp_q);
    chk("post_rst_words_read", words_read, 2);
    chk("post_rst_done_at", done_at, 5);
    chk("post_rst_done_cnt", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, data word width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, depth of the attached FIFO, carried for consistency only.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst.
REQ-006 SHALL have port burst_len  input  8  words to read; sampled with start.
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-009 SHALL have port rd_en  output  1  read strobe to the FIFO.
REQ-010 SHALL have port data_out  input  FIFO_WIDTH  FIFO read data, valid the cycle after rd_en.
REQ-011 SHALL have ports empty and underflow  input  1 each  FIFO status flags.
REQ-012 SHALL have port m_data  output  FIFO_WIDTH  downstream data.
REQ-013 SHALL have ports m_valid (output, 1) and m_ready (input, 1) as the downstream handshake.
REQ-014 SHALL have port words_read  output  8  count of downstream handshakes in the current burst.
REQ-015 SHALL have port err_underflow  output  1  sticky underflow error flag.

Function
REQ-016 SHALL implement states IDLE, READ, DRAIN, DONE.
- IDLE->READ on start with burst_len>0.
- IDLE->DONE on start with burst_len==0.
- READ->DRAIN when remaining reaches 0.
- DRAIN->DONE when inflight==0 and occ==0.
- DONE->IDLE unconditionally.
REQ-017 SHALL ignore start while busy.
REQ-018 SHALL, on an accepted start, load remaining=burst_len, clear words_read and clear err_underflow.
REQ-019 SHALL assert rd_en only in READ, and only when all hold: !empty; remaining>0; (occ + inflight - pop) < 2. Here occ is the skid buffer occupancy (0..2), inflight is rd_en of the previous cycle, and pop = m_valid && m_ready.
REQ-020 SHALL decrement remaining by one on each cycle with rd_en high.
REQ-021 SHALL push data_out into the skid buffer tail in the cycle after rd_en, unless underflow is high in that cycle.
REQ-022 SHALL, on underflow during a capture cycle, discard the word and set err_underflow until the next accepted start or reset.
REQ-023 SHALL drive m_valid = (occ>0) and m_data = buffer head, preserving FIFO order.
REQ-024 SHALL hold m_data and m_valid stable while m_valid && !m_ready.
REQ-025 SHALL sustain one word per cycle when empty stays low and m_ready stays high.
REQ-026 SHALL have latency: start in cycle t gives first rd_en in t+1 and first m_valid in t+3 if the FIFO is non-empty.
REQ-027 SHALL stall in READ while empty is high, with no timeout.
REQ-028 SHALL increment words_read on each pop, saturating at 255.
REQ-029 SHALL pulse done for exactly one cycle in DONE; with burst_len==0, done is high in t+1 and rd_en is never asserted.
REQ-030 SHALL handle a simultaneous push and pop in the same cycle with occ unchanged.

Reset
REQ-031 SHALL, on rst_n low, immediately clear: state=IDLE, rd_en=0, busy=0, done=0, m_valid=0, m_data=0, words_read=0, err_underflow=0, occ=0, inflight=0, remaining=0.
REQ-032 SHALL drop any in-flight or buffered word on reset mid-burst; no done pulse is issued.

Structure
REQ-033 SHALL take FIFO_WIDTH, FIFO_DEPTH defaults and the state typedef (rd_state_e) from shared package fifo_pkg.
REQ-034 SHALL place the 2-entry skid buffer in sub-module fifo_rd_skid (push, pop, occ, head).

Verification
REQ-035 SHALL cover: FIFO preloaded with 0x0001..0x0005, start with burst_len=5, m_ready=1 -> five consecutive m_valid cycles from t+3, data in order, done at t+8, words_read=5.
REQ-036 SHALL cover: burst_len=4, m_ready low for 3 cycles mid-burst -> at most 2 words buffered, m_data held stable, no word lost or duplicated, words_read=4.
REQ-037 SHALL cover: FIFO holds 2 words, burst_len=4, 2 more words written 10 cycles later -> reader stalls in READ, then completes, done pulses once.
REQ-038 SHALL cover: burst_len=0 -> done at t+1, rd_en never high, busy high for one cycle.
REQ-039 SHALL cover: forced underflow on a capture cycle -> word discarded, err_underflow=1 until next start.
REQ-040 SHALL cover: rst_n low during burst with 2 words buffered -> all outputs zero immediately, a new start afterwards works normally.
